// File: rtl/snn_layer_sequencer.sv
// Serial-MAC controller for one fully connected LIF spiking layer fed by an external synchronous weight memory.
// Optional feature macro: SNN_REFRACTORY_EN (per-neuron refractory down-counters).
module snn_layer_sequencer #(
  parameter int WIDTH        = 16,
  parameter int N_INPUTS     = 2,
  parameter int N_NEURONS    = 3,
  parameter int FRAC_BITS    = 0,
  parameter int LEAK_SHIFT   = 3,
  parameter int THRESH       = 100,
  parameter int REFRAC_STEPS = 2,
  localparam int AW = (N_NEURONS*N_INPUTS > 1) ? $clog2(N_NEURONS*N_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_INPUTS*WIDTH-1:0]   input_vector,
  output logic                        w_rd_en,
  output logic [AW-1:0]               w_addr,
  input  logic [WIDTH-1:0]            w_data,
  output logic [N_NEURONS-1:0]        spike_out,
  output logic                        spike_valid,
  output logic                        busy
);
  localparam int IW   = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1;
  localparam int JW   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int ACCW = 2*WIDTH + $clog2(N_INPUTS) + 1;
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] THR_W = WIDTH'(THRESH);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_FIRE, S_DONE} state_e;

  state_e                           state_q;
  logic [N_INPUTS-1:0][WIDTH-1:0]   x_q;
  logic [IW-1:0]                    i_q;
  logic [JW-1:0]                    j_q;
  logic signed [ACCW-1:0]           acc_q;
  logic signed [WIDTH-1:0]          v_q [N_NEURONS];
  logic [N_NEURONS-1:0]             spk_q;
  logic [N_NEURONS-1:0]             spike_out_q;
  logic                             spike_valid_q;
  logic                             w_rd_en_q;
  logic [AW-1:0]                    w_addr_q;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACCW-1:0] x);
    logic signed [ACCW-1:0] r;
    r = x;
    if (x > SMAX) r = SMAX;
    else if (x < SMIN) r = SMIN;
    return r[WIDTH-1:0];
  endfunction

  // The weight returned this cycle belongs to the previous issue, i.e. input i-1 (or the last one in DRAIN).
  logic [IW-1:0]             pidx;
  logic signed [WIDTH-1:0]   xsel, d_sat, v_new;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]    prod_ext, acc_sum, acc_sh, v_ext, d_ext, v_sum;
  logic                      fire, refr;

  assign pidx     = (state_q == S_DRAIN) ? IW'(N_INPUTS-1) : i_q - IW'(1);
  assign xsel     = $signed(x_q[pidx]);
  assign prod     = xsel * $signed(w_data);
  assign prod_ext = prod;
  assign acc_sum  = acc_q + prod_ext;
  assign acc_sh   = acc_q >>> FRAC_BITS;
  assign d_sat    = sat(acc_sh);
  assign v_ext    = v_q[j_q];
  assign d_ext    = d_sat;
  assign v_sum    = v_ext - (v_ext >>> LEAK_SHIFT) + d_ext;
  assign v_new    = sat(v_sum);
  assign fire     = (v_new >= THR_W);

`ifdef SNN_REFRACTORY_EN
  localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS+1) : 1;
  logic [RW-1:0] rc_q [N_NEURONS];
  assign refr = (rc_q[j_q] != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURONS; n++) rc_q[n] <= '0;
    end else if (state_q == S_FIRE) begin
      if (refr) rc_q[j_q] <= rc_q[j_q] - RW'(1);
      else if (fire) rc_q[j_q] <= RW'(REFRAC_STEPS);
    end
  end
`else
  assign refr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      i_q           <= '0;
      j_q           <= '0;
      acc_q         <= '0;
      spk_q         <= '0;
      spike_out_q   <= '0;
      spike_valid_q <= 1'b0;
      w_rd_en_q     <= 1'b0;
      w_addr_q      <= '0;
      for (int n = 0; n < N_NEURONS; n++) v_q[n] <= '0;
    end else begin
      spike_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (in_valid) begin
          x_q       <= input_vector;
          i_q       <= '0;
          j_q       <= '0;
          acc_q     <= '0;
          w_rd_en_q <= 1'b1;
          w_addr_q  <= '0;
          state_q   <= S_MAC;
        end
        S_MAC: begin
          if (i_q != '0) acc_q <= acc_sum;
          if (i_q == IW'(N_INPUTS-1)) begin
            w_rd_en_q <= 1'b0;
            state_q   <= S_DRAIN;
          end else begin
            i_q      <= i_q + IW'(1);
            w_addr_q <= w_addr_q + AW'(1);
          end
        end
        S_DRAIN: begin
          acc_q   <= acc_sum;
          state_q <= S_FIRE;
        end
        S_FIRE: begin
          // Refractory neurons still ran their MAC so timestep latency stays fixed.
          if (refr || fire) v_q[j_q] <= '0;
          else              v_q[j_q] <= v_new;
          spk_q[j_q] <= fire && !refr;
          if (j_q == JW'(N_NEURONS-1)) begin
            state_q <= S_DONE;
          end else begin
            j_q       <= j_q + JW'(1);
            i_q       <= '0;
            acc_q     <= '0;
            w_rd_en_q <= 1'b1;
            w_addr_q  <= w_addr_q + AW'(1);
            state_q   <= S_MAC;
          end
        end
        S_DONE: begin
          spike_out_q   <= spk_q;
          spike_valid_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !reset;
  assign busy        = (state_q != S_IDLE);
  assign w_rd_en     = w_rd_en_q;
  assign w_addr      = w_addr_q;
  assign spike_out   = spike_out_q;
  assign spike_valid = spike_valid_q;
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Scoreboard bench for snn_layer_sequencer: a timestep-level LIF model predicts each spike vector and its arrival cycle.
module tb_snn_layer_sequencer;
  localparam int W    = 16;
  localparam int NI   = 2;
  localparam int NN   = 3;
  localparam int FRAC = 0;
  localparam int LEAK = 3;
  localparam int THR  = 100;
  localparam int REFR = 2;
  localparam int LAT  = NN*(NI+2)+1;
  localparam int AW   = $clog2(NN*NI);

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready, w_rd_en, spike_valid, busy;
  logic [NI*W-1:0]   input_vector;
  logic [AW-1:0]     w_addr;
  logic [W-1:0]      w_data;
  logic [NN-1:0]     spike_out;

  snn_layer_sequencer #(.WIDTH(W), .N_INPUTS(NI), .N_NEURONS(NN), .FRAC_BITS(FRAC),
                        .LEAK_SHIFT(LEAK), .THRESH(THR), .REFRAC_STEPS(REFR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_vector(input_vector), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .spike_out(spike_out), .spike_valid(spike_valid), .busy(busy));

  always #5 clk = ~clk;

  int w_m [NN*NI];
  int v_m [NN];
  int rc_m [NN];

  // Synchronous weight memory: data one cycle after the read strobe.
  always @(posedge clk) if (w_rd_en) w_data <= W'(w_m[w_addr]);

  typedef struct { logic [NN-1:0] spk; int cyc; } exp_t;
  exp_t sb [$];

  int checks = 0, failures = 0;
  int cyc = 0, acc_c = 0;
  bit have_acc = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic longint sat(longint a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // One whole timestep of the layer: dot product, leak, threshold, reset-to-zero.
  function automatic logic [NN-1:0] model_step(logic [NI*W-1:0] vec);
    logic [NN-1:0] s = '0;
    longint acc, d, vn;
    for (int j = 0; j < NN; j++) begin
      acc = 0;
      for (int i = 0; i < NI; i++)
        acc += longint'($signed(vec[i*W +: W])) * longint'(w_m[j*NI+i]);
      d  = sat(acc >>> FRAC);
      vn = sat(longint'(v_m[j]) - (longint'(v_m[j]) >>> LEAK) + d);
`ifdef SNN_REFRACTORY_EN
      if (rc_m[j] > 0) begin
        rc_m[j]--;
        v_m[j] = 0;
      end else
`endif
      if (vn >= THR) begin
        s[j] = 1'b1;
        v_m[j] = 0;
        rc_m[j] = REFR;
      end else begin
        v_m[j] = int'(vn);
      end
    end
    return s;
  endfunction

  function automatic logic [NI*W-1:0] pack(int a0, int a1);
    return {W'(a1), W'(a0)};
  endfunction

  // Accept observer: predicts the result at the moment of transfer.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) have_acc = 1'b0;
    else if (in_valid && in_ready) begin
      sb.push_back('{spk: model_step(input_vector), cyc: cyc});
      have_acc = 1'b1;
      acc_c = cyc;
    end
  end

  // Output monitor.
  initial forever begin
    bit exp_busy;
    exp_t e;
    @(negedge clk);
    #1;
    exp_busy = have_acc && !reset && ((cyc - acc_c) < LAT);
    chk("in_ready", in_ready, !exp_busy && !reset);
    chk("busy", busy, exp_busy);
    if (w_rd_en) chk("w_addr_range", (w_addr < NN*NI), 1);
    if (spike_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL spike_valid_unexpected actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("spike_out", spike_out, e.spk);
        chk("latency", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic do_reset(int n);
    reset = 1'b1;
    sb.delete();
    for (int k = 0; k < NN; k++) begin v_m[k] = 0; rc_m[k] = 0; end
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Offer `vec` until n transfers happen; junk is driven while the DUT is busy.
  task automatic run_steps(int n, logic [NI*W-1:0] vec, bit hold);
    int cnt = 0, guard = 0;
    while (cnt < n) begin
      @(negedge clk);
      guard++;
      if (guard > n*(LAT+2) + 20) begin
        checks++; failures++;
        $display("FAIL accept_timeout actual=%0d required=%0d", cnt, n);
        break;
      end
      if (in_ready) begin
        in_valid = 1'b1;
        input_vector = vec;
        cnt++;
      end else begin
        in_valid = hold ? 1'b1 : 1'($urandom);
        input_vector = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    input_vector = {$urandom, $urandom};
  endtask

  task automatic drain();
    repeat (LAT+3) @(negedge clk);
  endtask

  task automatic set_all_w(int w);
    for (int k = 0; k < NN*NI; k++) w_m[k] = w;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; input_vector = '0;
    set_all_w(1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_spike_out", spike_out, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_w_rd_en", w_rd_en, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    do_reset(1);

    // Sustained drive, in_valid held high: back-to-back timesteps.
    run_steps(10, pack(10, 10), 1'b1);
    drain();

    // Mixed-sign weights.
    do_reset(2);
    w_m[0] = 1; w_m[1] = 1; w_m[2] = 2; w_m[3] = -1; w_m[4] = 0; w_m[5] = 0;
    run_steps(6, pack(20, -10), 1'b0);
    drain();

    // Positive saturation.
    do_reset(2);
    set_all_w(32767);
    run_steps(2, pack(32767, 32767), 1'b1);
    drain();

    // Negative saturation.
    do_reset(2);
    set_all_w(-32768);
    run_steps(3, pack(32767, 32767), 1'b0);
    drain();

    // Negative leak.
    do_reset(2);
    set_all_w(1);
    run_steps(12, pack(-10, -10), 1'b0);
    drain();

    // Random weights and inputs with idle gaps.
    do_reset(2);
    for (int k = 0; k < NN*NI; k++) w_m[k] = int'($urandom_range(0, 8)) - 3;
    for (int s = 0; s < 30; s++) begin
      run_steps(1, pack(int'($urandom_range(0, 80)) - 20, int'($urandom_range(0, 80)) - 20), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Abort five cycles into a timestep after some membrane build-up.
    do_reset(2);
    set_all_w(1);
    run_steps(3, pack(10, 10), 1'b0);
    repeat (4) @(negedge clk);
    do_reset(0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_spike_out", spike_out, 0);
    chk("abort_spike_valid", spike_valid, 0);
    chk("abort_w_rd_en", w_rd_en, 0);
    chk("abort_w_addr", w_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_abort", in_ready, 1);
    drain();
    run_steps(8, pack(10, 10), 1'b1);
    drain();

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
